// File: rtl/ipv4_parser.sv
// IPv4 receive parser: validates the header of each Ethernet payload, strips it and the
// Ethernet padding, and forwards the IP payload with frame-level error status on its last byte.
module ipv4_parser #(
    parameter logic [31:0] LOCAL_IP     = 32'hC0A8_00C7,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter bit          CHECK_CSUM   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  eth_data_in,
    input  logic        eth_byte_valid,
    input  logic        eth_eof,
    input  logic        eth_err,
    output logic [7:0]  ip_data_out,
    output logic        ip_byte_valid,
    output logic        ip_eof,
    output logic        ip_err,
    output logic [31:0] src_ip,
    output logic        hdr_drop
);

    typedef enum logic [1:0] {HEADER, PAYLOAD, PAD, DROP} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  ver_q, ver_d;
    logic [3:0]  ihl_q, ihl_d;
    logic [15:0] tot_len_q, tot_len_d;
    logic [13:0] frag_q, frag_d;      // {MF, fragment offset}
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [7:0]  csum_hi_q, csum_hi_d;
    logic [15:0] csum_q, csum_d;
    logic [16:0] csum_sum;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  ip_data_q, ip_data_d;
    logic        ip_valid_q, ip_valid_d;
    logic        ip_eof_q, ip_eof_d;
    logic        ip_err_q, ip_err_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic        hdr_drop_q, hdr_drop_d;

    logic [15:0] hdr_len;
    logic        hdr_last;
    logic        hdr_bad;
    logic        dst_ok;
    logic        pay_last;

    // Header field capture and running one's-complement checksum.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        ver_d     = ver_q;
        ihl_d     = ihl_q;
        tot_len_d = tot_len_q;
        frag_d    = frag_q;
        proto_d   = proto_q;
        src_d     = src_q;
        dst_d     = dst_q;
        csum_hi_d = csum_hi_q;
        csum_d    = csum_q;
        csum_sum  = {1'b0, csum_q} + {1'b0, csum_hi_q, eth_data_in};
        if (state_q == HEADER && eth_byte_valid) begin
            case (cnt_q)
                16'd0:  begin ver_d = eth_data_in[7:4]; ihl_d = eth_data_in[3:0]; end
                16'd2:  tot_len_d[15:8] = eth_data_in;
                16'd3:  tot_len_d[7:0]  = eth_data_in;
                16'd6:  frag_d[13:8]    = eth_data_in[5:0];
                16'd7:  frag_d[7:0]     = eth_data_in;
                16'd9:  proto_d         = eth_data_in;
                16'd12, 16'd13, 16'd14, 16'd15: src_d = {src_q[23:0], eth_data_in};
                16'd16, 16'd17, 16'd18, 16'd19: dst_d = {dst_q[23:0], eth_data_in};
                default: ;
            endcase
            if (cnt_q[0]) begin
                csum_d = csum_sum[15:0] + {15'd0, csum_sum[16]};
            end else begin
                csum_hi_d = eth_data_in;
                if (cnt_q == 16'd0) csum_d = 16'd0;
            end
        end
    end

    // A bad IHL still consumes 20 bytes so the rejection happens at a defined point.
    assign hdr_len  = (ihl_d < 4'd5) ? 16'd20 : {10'd0, ihl_d, 2'b00};
    assign hdr_last = (cnt_q == hdr_len - 16'd1);
    assign dst_ok   = (dst_d == LOCAL_IP) || (ACCEPT_BCAST && (dst_d == 32'hFFFF_FFFF));
    assign hdr_bad  = (ver_d != 4'd4) || (ihl_d < 4'd5) || (tot_len_d <= hdr_len)
                   || (proto_d != 8'h11) || (frag_d != 14'd0) || !dst_ok
                   || (CHECK_CSUM && (csum_d != 16'hFFFF));
    assign pay_last = (cnt_q == tot_len_q - 16'd1);

    always_comb begin
        state_d = state_q;
        if (eth_byte_valid) begin
            case (state_q)
                HEADER: begin
                    if (eth_eof)       state_d = HEADER;
                    else if (hdr_last) state_d = hdr_bad ? DROP : PAYLOAD;
                end
                PAYLOAD: begin
                    if (eth_eof)       state_d = HEADER;
                    else if (pay_last) state_d = PAD;
                end
                PAD, DROP: if (eth_eof) state_d = HEADER;
                default: state_d = HEADER;
            endcase
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        ip_data_d  = ip_data_q;
        ip_valid_d = 1'b0;
        ip_eof_d   = 1'b0;
        ip_err_d   = 1'b0;
        src_ip_d   = src_ip_q;
        hdr_drop_d = 1'b0;
        if (eth_byte_valid) begin
            cnt_d = eth_eof ? 16'd0 : cnt_q + 16'd1;
            case (state_q)
                HEADER: begin
                    if (eth_eof || hdr_last) hdr_drop_d = eth_eof || hdr_bad;
                    if (!eth_eof && hdr_last && !hdr_bad) src_ip_d = src_d;
                end
                PAYLOAD: begin
                    if (pay_last && !eth_eof) begin
                        hold_d = eth_data_in;
                    end else begin
                        ip_valid_d = 1'b1;
                        ip_data_d  = eth_data_in;
                        ip_eof_d   = eth_eof;
                        // An early eof means the frame was truncated.
                        ip_err_d   = eth_eof && (eth_err || !pay_last);
                    end
                end
                PAD: begin
                    if (eth_eof) begin
                        ip_valid_d = 1'b1;
                        ip_data_d  = hold_q;
                        ip_eof_d   = 1'b1;
                        ip_err_d   = eth_err;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HEADER;
            cnt_q      <= '0;
            ver_q      <= '0;
            ihl_q      <= '0;
            tot_len_q  <= '0;
            frag_q     <= '0;
            proto_q    <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            csum_hi_q  <= '0;
            csum_q     <= '0;
            hold_q     <= '0;
            ip_data_q  <= '0;
            ip_valid_q <= 1'b0;
            ip_eof_q   <= 1'b0;
            ip_err_q   <= 1'b0;
            src_ip_q   <= '0;
            hdr_drop_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ver_q      <= ver_d;
            ihl_q      <= ihl_d;
            tot_len_q  <= tot_len_d;
            frag_q     <= frag_d;
            proto_q    <= proto_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            csum_hi_q  <= csum_hi_d;
            csum_q     <= csum_d;
            hold_q     <= hold_d;
            ip_data_q  <= ip_data_d;
            ip_valid_q <= ip_valid_d;
            ip_eof_q   <= ip_eof_d;
            ip_err_q   <= ip_err_d;
            src_ip_q   <= src_ip_d;
            hdr_drop_q <= hdr_drop_d;
        end
    end

    assign ip_data_out   = ip_data_q;
    assign ip_byte_valid = ip_valid_q;
    assign ip_eof        = ip_eof_q;
    assign ip_err        = ip_err_q;
    assign src_ip        = src_ip_q;
    assign hdr_drop      = hdr_drop_q;

endmodule

// File: tb/tb_ipv4_parser.sv
// Directed bench for ipv4_parser: expected payload bytes go into a scoreboard queue as frames
// are driven and are popped and compared when the parser emits them.
module tb_ipv4_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  eth_data_in;
    logic        eth_byte_valid, eth_eof, eth_err;
    logic [7:0]  ip_data_out;
    logic        ip_byte_valid, ip_eof, ip_err, hdr_drop;
    logic [31:0] src_ip;
    logic [7:0]  ip2_data;
    logic        ip2_valid, ip2_eof, ip2_err, drop2;
    logic [31:0] src2;

    always #5 clk = ~clk;

    ipv4_parser dut (
        .clk(clk), .rst(rst), .eth_data_in(eth_data_in), .eth_byte_valid(eth_byte_valid),
        .eth_eof(eth_eof), .eth_err(eth_err), .ip_data_out(ip_data_out),
        .ip_byte_valid(ip_byte_valid), .ip_eof(ip_eof), .ip_err(ip_err),
        .src_ip(src_ip), .hdr_drop(hdr_drop)
    );

    ipv4_parser #(.CHECK_CSUM(1'b0)) dut_nocsum (
        .clk(clk), .rst(rst), .eth_data_in(eth_data_in), .eth_byte_valid(eth_byte_valid),
        .eth_eof(eth_eof), .eth_err(eth_err), .ip_data_out(ip2_data),
        .ip_byte_valid(ip2_valid), .ip_eof(ip2_eof), .ip_err(ip2_err),
        .src_ip(src2), .hdr_drop(drop2)
    );

    typedef struct {
        logic [7:0]  data;
        logic        eof;
        logic        err;
        logic [31:0] src;
        int          at;     // input-byte count at which the output must appear
    } exp_t;

    exp_t       sb[$];
    logic [7:0] hdr_q[$];
    int n_assert = 0, n_fail = 0;
    int in_cnt = 0, sent_cnt = 0, drop_cnt = 0, exp_drops = 0, n2 = 0;
    bit gap_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) if (!rst && eth_byte_valid) in_cnt++;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (hdr_drop) drop_cnt++;
            if (ip2_valid) n2++;
            if (ip_err) check("err_without_eof", {31'd0, ip_eof}, 32'd1);
            if (ip_byte_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {31'd0, ip_byte_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("data", {24'd0, ip_data_out}, {24'd0, e.data});
                    check("eof", {31'd0, ip_eof}, {31'd0, e.eof});
                    check("err", {31'd0, ip_err}, {31'd0, e.err});
                    check("src_ip", src_ip, e.src);
                    check("latency", in_cnt, e.at);
                end
            end
        end
    end

    task automatic build_hdr(input logic [3:0] ihl, input logic [15:0] tot, input logic [15:0] frag,
                             input logic [7:0] proto, input logic [31:0] src,
                             input logic [31:0] dst, input bit bad);
        logic [16:0] s;
        logic [15:0] cs;
        hdr_q.delete();
        hdr_q.push_back({4'h4, ihl}); hdr_q.push_back(8'h00);
        hdr_q.push_back(tot[15:8]);   hdr_q.push_back(tot[7:0]);
        hdr_q.push_back(8'h00);       hdr_q.push_back(8'h00);
        hdr_q.push_back(frag[15:8]);  hdr_q.push_back(frag[7:0]);
        hdr_q.push_back(8'h40);       hdr_q.push_back(proto);
        hdr_q.push_back(8'h00);       hdr_q.push_back(8'h00);
        for (int i = 3; i >= 0; i--) hdr_q.push_back(src[8*i +: 8]);
        for (int i = 3; i >= 0; i--) hdr_q.push_back(dst[8*i +: 8]);
        for (int i = 20; i < int'(ihl) * 4; i++) hdr_q.push_back(8'(i));
        s = '0;
        for (int i = 0; i < hdr_q.size(); i += 2) begin
            s = {1'b0, s[15:0]} + {1'b0, hdr_q[i], hdr_q[i+1]};
            s = {1'b0, s[15:0]} + 17'(s[16]);
        end
        cs = ~s[15:0];
        if (bad) cs = cs + 16'd1;
        hdr_q[10] = cs[15:8];
        hdr_q[11] = cs[7:0];
    endtask

    task automatic send_byte(input logic [7:0] d, input bit eof, input bit err);
        int n;
        if (gap_en) begin
            n = $urandom_range(0, 2);
            eth_byte_valid = 1'b0;
            repeat (n) begin @(posedge clk); #1; end
        end
        eth_data_in    = d;
        eth_byte_valid = 1'b1;
        eth_eof        = eof;
        eth_err        = err;
        @(posedge clk); #1;
        sent_cnt++;
        eth_byte_valid = 1'b0;
        eth_eof        = 1'b0;
        eth_err        = 1'b0;
    endtask

    // plen = IP payload length from Total Length, npay = payload bytes actually sent.
    task automatic send_frame(input bit pass, input int plen, input int npay, input int pad,
                              input bit err, input logic [31:0] src);
        logic [7:0] d, hold;
        bit         last;
        exp_t       e;
        hold = 8'h00;
        foreach (hdr_q[i]) send_byte(hdr_q[i], 1'b0, 1'b0);
        for (int i = 0; i < npay; i++) begin
            d    = 8'($urandom);
            last = (i == npay - 1) && (pad == 0);
            if (pass) begin
                if (i == plen - 1 && pad > 0) begin
                    hold = d;
                end else begin
                    e.data = d; e.eof = last; e.err = last && (err || npay < plen);
                    e.src = src; e.at = sent_cnt + 1;
                    sb.push_back(e);
                end
            end
            send_byte(d, last, last && err);
        end
        if (pass && pad > 0) begin
            e.data = hold; e.eof = 1'b1; e.err = err; e.src = src; e.at = sent_cnt + pad;
            sb.push_back(e);
        end
        for (int i = 0; i < pad; i++) send_byte(8'hA5 ^ 8'(i), i == pad - 1, (i == pad - 1) && err);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_queue_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_drops"}, 32'(drop_cnt), 32'(exp_drops));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n2_before;
        exp_t e;
        rst = 1'b1; eth_data_in = 8'h00; eth_byte_valid = 1'b0; eth_eof = 1'b0; eth_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", {31'd0, ip_byte_valid}, 32'd0);
        check("rst_eof", {31'd0, ip_eof}, 32'd0);
        check("rst_err", {31'd0, ip_err}, 32'd0);
        check("rst_drop", {31'd0, hdr_drop}, 32'd0);
        check("rst_src", src_ip, 32'd0);
        check("rst_data", {24'd0, ip_data_out}, 32'd0);

        // Good frame, 95 payload bytes, eof on the last one.
        build_hdr(4'd5, 16'h0073, 16'h4000, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b0);
        send_frame(1'b1, 95, 95, 0, 1'b0, 32'hC0A8_0001);
        drain("good");

        // Checksum off by one: dropped here, accepted by the unchecked instance.
        n2_before = n2;
        build_hdr(4'd5, 16'h0073, 16'h4000, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b1);
        exp_drops++;
        send_frame(1'b0, 95, 95, 0, 1'b0, 32'hC0A8_0001);
        drain("bad_csum");
        check("nocsum_bytes", 32'(n2 - n2_before), 32'd95);

        // 8-byte payload followed by 18 pad bytes, error flagged on the last pad byte.
        build_hdr(4'd5, 16'h001C, 16'h4000, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b0);
        send_frame(1'b1, 8, 8, 18, 1'b1, 32'hC0A8_0001);
        drain("padded");

        // Truncated after 40 of 95 payload bytes.
        build_hdr(4'd5, 16'h0073, 16'h4000, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b0);
        send_frame(1'b1, 95, 40, 0, 1'b0, 32'hC0A8_0001);
        drain("truncated");

        // Three rejected headers, then a good frame, all back-to-back.
        build_hdr(4'd5, 16'h0073, 16'h4000, 8'h06, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b0);
        send_frame(1'b0, 95, 95, 0, 1'b0, 32'hC0A8_0001);
        build_hdr(4'd5, 16'h0073, 16'h4000, 8'h11, 32'hC0A8_0001, 32'hC0A8_0002, 1'b0);
        send_frame(1'b0, 95, 95, 0, 1'b0, 32'hC0A8_0001);
        build_hdr(4'd5, 16'h0073, 16'h2000, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b0);
        send_frame(1'b0, 95, 95, 0, 1'b0, 32'hC0A8_0001);
        exp_drops += 3;
        build_hdr(4'd5, 16'h0030, 16'h0000, 8'h11, 32'hC0A8_0033, 32'hC0A8_00C7, 1'b0);
        send_frame(1'b1, 28, 28, 0, 1'b0, 32'hC0A8_0033);
        drain("rejects_then_good");

        // IHL=6 with options, broadcast destination and random valid gaps.
        gap_en = 1'b1;
        build_hdr(4'd6, 16'd54, 16'h0000, 8'h11, 32'h0A00_0001, 32'hFFFF_FFFF, 1'b0);
        send_frame(1'b1, 30, 30, 0, 1'b0, 32'h0A00_0001);
        gap_en = 1'b0;
        drain("options_gaps");

        // eof inside the header, then a good frame immediately after.
        build_hdr(4'd5, 16'h0073, 16'h4000, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(hdr_q[i], i == 9, 1'b0);
        exp_drops++;
        send_frame(1'b1, 95, 95, 0, 1'b0, 32'hC0A8_0001);
        drain("hdr_eof");

        // Reset in the middle of a payload.
        build_hdr(4'd5, 16'h0073, 16'h4000, 8'h11, 32'hC0A8_0077, 32'hC0A8_00C7, 1'b0);
        foreach (hdr_q[i]) send_byte(hdr_q[i], 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            e.data = 8'(8'h60 + i); e.eof = 1'b0; e.err = 1'b0;
            e.src = 32'hC0A8_0077; e.at = sent_cnt + 1;
            sb.push_back(e);
            send_byte(e.data, 1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        rst = 1'b1; eth_byte_valid = 1'b1; eth_data_in = 8'h3C;
        @(posedge clk);
        #1;
        check("midrst_valid", {31'd0, ip_byte_valid}, 32'd0);
        check("midrst_data", {24'd0, ip_data_out}, 32'd0);
        check("midrst_src", src_ip, 32'd0);
        check("midrst_eof", {31'd0, ip_eof}, 32'd0);
        rst = 1'b0; eth_byte_valid = 1'b0;
        drain("mid_reset");

        build_hdr(4'd5, 16'h0020, 16'h4000, 8'h11, 32'hC0A8_0009, 32'hC0A8_00C7, 1'b0);
        send_frame(1'b1, 12, 12, 0, 1'b0, 32'hC0A8_0009);
        drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
